// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] FUN3MUL    = 3'b000;
  localparam logic [2:0] FUN3MULH   = 3'b001;
  localparam logic [2:0] FUN3MULHSU = 3'b010;
  localparam logic [2:0] FUN3MULHU  = 3'b011;
  localparam logic [2:0] FUN3DIV    = 3'b100;
  localparam logic [2:0] FUN3DIVU   = 3'b101;
  localparam logic [2:0] FUN3REM    = 3'b110;
  localparam logic [2:0] FUN3REMU   = 3'b111;

  localparam logic [6:0] FUN7MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == FUN3MULH) || (f3 == FUN3MULHSU) ||
           (f3 == FUN3DIV)  || (f3 == FUN3REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == FUN3MULH) || (f3 == FUN3DIV) || (f3 == FUN3REM);
  endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// Unsigned radix-2 datapath: 2*WIDTH shift register with the shift-add
// (multiply) or restoring-subtract (divide) step.
module muldiv_shift_core #(
  parameter int WIDTH = 32
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iLoad,
  input  logic               iStep,
  input  logic               iDiv,
  input  logic [WIDTH-1:0]   iLo,
  input  logic [WIDTH-1:0]   iOpnd,
  output logic [2*WIDTH-1:0] oAcc
);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               rem_ge;

  // one iteration: multiply shifts right with carry, divide shifts left and trial-subtracts
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (div_q)
      acc_step = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], rem_ge};
    else
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // load operands on accept, then advance one step per enabled cycle
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (iLoad) begin
      acc_q  <= {{WIDTH{1'b0}}, iLo};
      opnd_q <= iOpnd;
      div_q  <= iDiv;
    end else if (iStep) begin
      acc_q  <= acc_step;
    end
  end

  assign oAcc = acc_q;

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for a request, operands captured on accept
// CALC  | one radix-2 step per cycle, WIDTH cycles
// SIGN  | apply result sign / special-case override, pick result half
// DONE  | result held valid until the consumer takes it
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid,
  output logic             oReady,
  input  logic [2:0]       iFunct3,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oBusy
);

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES     = '1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_SIGN = SIGN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state_q;
  logic [2:0]         f3_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               spec_q;
  logic [WIDTH-1:0]   spec_res_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_zero, div_ovf, special;
  logic [WIDTH-1:0]   spec_res;
  logic [2*WIDTH-1:0] core_acc;
  logic [2*WIDTH-1:0] prod_sel;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   sign_res;

  // request decode: magnitudes, signs and the RISC-V special cases
  always_comb begin
    accept   = (state_q == ST_IDLE) && iValid && !iFlush;
    a_neg    = a_signed(iFunct3) && iA[WIDTH-1];
    b_neg    = b_signed(iFunct3) && iB[WIDTH-1];
    abs_a    = a_neg ? -iA : iA;
    abs_b    = b_neg ? -iB : iB;
    div_zero = is_div(iFunct3) && (iB == '0);
    div_ovf  = is_div(iFunct3) && !iFunct3[0] && (iA == MIN_VAL) && (iB == ONES);
    special  = div_zero || div_ovf;
    if (div_zero)
      spec_res = is_rem(iFunct3) ? iA : ONES;
    else
      spec_res = is_rem(iFunct3) ? '0 : MIN_VAL;
  end

  muldiv_shift_core #(.WIDTH(WIDTH)) u_core (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iLoad (accept),
    .iStep (state_q == ST_CALC),
    .iDiv  (is_div(iFunct3)),
    .iLo   (is_div(iFunct3) ? abs_a : abs_b),
    .iOpnd (is_div(iFunct3) ? abs_b : abs_a),
    .oAcc  (core_acc)
  );

  // sign fix-up and result-half selection used in SIGN
  always_comb begin
    prod_sel = neg_res_q ? -core_acc : core_acc;
    quo      = core_acc[WIDTH-1:0];
    rem      = core_acc[2*WIDTH-1:WIDTH];
    if (spec_q)
      sign_res = spec_res_q;
    else if (is_div(f3_q))
      sign_res = is_rem(f3_q) ? (neg_rem_q ? -rem : rem) : (neg_res_q ? -quo : quo);
    else
      sign_res = (f3_q == FUN3MUL) ? prod_sel[WIDTH-1:0] : prod_sel[2*WIDTH-1:WIDTH];
  end

  // control FSM, operand attributes and result register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      f3_q       <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else if (iFlush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iValid) begin
            f3_q       <= iFunct3;
            cnt_q      <= CNT_INIT;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            spec_q     <= special;
            spec_res_q <= spec_res;
            if (FAST_SPEC && special) begin
              result_q <= spec_res;
              state_q  <= ST_DONE;
            end else begin
              state_q  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (cnt_q == '0) state_q <= ST_SIGN;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_SIGN: begin
          result_q <= sign_res;
          state_q  <= ST_DONE;
        end
        default: begin
          if (iReady) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign oReady  = (state_q == ST_IDLE);
  assign oValid  = (state_q == ST_DONE);
  assign oBusy   = (state_q == ST_CALC) || (state_q == ST_SIGN);
  assign oResult = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit (WIDTH=32, FAST_SPEC=1).
module tb_muldiv_iter_unit;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iValid;
  logic        oReady;
  logic [2:0]  iFunct3;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  logic [31:0] oResult;
  logic        oBusy;

  int errors = 0;
  int checks = 0;

  muldiv_iter_unit #(.WIDTH(32), .FAST_SPEC(1'b1)) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iValid  (iValid),
    .oReady  (oReady),
    .iFunct3 (iFunct3),
    .iA      (iA),
    .iB      (iB),
    .iFlush  (iFlush),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult),
    .oBusy   (oBusy)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // issue one op, measure latency, optionally stall the consumer, then take the result
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int hold);
    int lat;
    lat = 0;
    while (!oReady && lat < 100) begin
      @(posedge iCLK); #1;
      lat++;
    end
    iFunct3 = f3; iA = a; iB = b; iValid = 1'b1;
    @(posedge iCLK); #1;
    iValid = 1'b0; iA = 32'hDEADBEEF; iB = 32'h12345678; iFunct3 = ~f3;
    lat = 1;
    while (!oValid && lat < 200) begin
      @(posedge iCLK); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, oResult, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge iCLK); #1;
      chk({tag, "_hold_valid"}, 32'(oValid), 32'd1);
      chk({tag, "_hold_res"}, oResult, exp_res);
      chk({tag, "_hold_ready"}, 32'(oReady), 32'd0);
    end
    iReady = 1'b1;
    @(posedge iCLK); #1;
    iReady = 1'b0;
    chk({tag, "_post_ready"}, 32'(oReady), 32'd1);
    chk({tag, "_post_valid"}, 32'(oValid), 32'd0);
  endtask

  initial begin
    int seen;
    iRST = 1'b1; iValid = 1'b0; iFunct3 = 3'b000; iA = '0; iB = '0;
    iFlush = 1'b0; iReady = 1'b0;
    #1;
    chk("rst_ready",  32'(oReady), 32'd1);
    chk("rst_valid",  32'(oValid), 32'd0);
    chk("rst_busy",   32'(oBusy),  32'd0);
    chk("rst_result", oResult,     32'd0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    @(posedge iCLK); #1;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    run_op("mulhu",  3'b011, 32'd7,        32'hFFFFFFFD, 32'h00000006, 34, 0);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34, 10);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        34, 0);
    run_op("div_z",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run_op("remu_z", 3'b111, 32'd5,        32'd0,        32'd5,        1,  0);
    run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);

    // flush together with valid in IDLE must not accept
    iFunct3 = 3'b000; iA = 32'd3; iB = 32'd4; iValid = 1'b1; iFlush = 1'b1;
    @(posedge iCLK); #1;
    iValid = 1'b0; iFlush = 1'b0;
    chk("flush_idle_ready", 32'(oReady), 32'd1);
    chk("flush_idle_busy",  32'(oBusy),  32'd0);

    // flush mid-CALC
    iFunct3 = 3'b101; iA = 32'd1000; iB = 32'd3; iValid = 1'b1;
    @(posedge iCLK); #1;
    iValid = 1'b0;
    repeat (5) @(posedge iCLK);
    #1;
    chk("flush_calc_busy", 32'(oBusy), 32'd1);
    iFlush = 1'b1;
    @(posedge iCLK); #1;
    iFlush = 1'b0;
    chk("flush_ready", 32'(oReady), 32'd1);
    chk("flush_busy",  32'(oBusy),  32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (oValid) seen = 1;
      @(posedge iCLK); #1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_op("after_flush", 3'b101, 32'd1000, 32'd3, 32'd333, 34, 0);

    // async reset mid-CALC
    iFunct3 = 3'b000; iA = 32'd9; iB = 32'd9; iValid = 1'b1;
    @(posedge iCLK); #1;
    iValid = 1'b0;
    repeat (11) @(posedge iCLK);
    #1;
    chk("rst_calc_busy", 32'(oBusy), 32'd1);
    #2 iRST = 1'b1;
    #1;
    chk("midrst_ready",  32'(oReady), 32'd1);
    chk("midrst_valid",  32'(oValid), 32'd0);
    chk("midrst_busy",   32'(oBusy),  32'd0);
    chk("midrst_result", oResult,     32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
    @(posedge iCLK); #1;
    run_op("after_rst", 3'b000, 32'd12345, 32'd1000, 32'd12345000, 34, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
